// File: rtl/pc_sequencer.sv
`timescale 1ns/1ps
// pc_sequencer: fetch-stage program counter with prioritised next-PC selection
// (branch > jump > RAS return > stall > sequential) and a circular
// return-address stack.
//
// Ports
//   Clk, Reset       rising-edge clock, asynchronous active-low reset
//   Stall            hold the PC unless a redirect is requested
//   BranchTaken/BranchTarget, Jump/JumpTarget   redirect requests
//   Ret              pop RAS and redirect to the popped address
//   Push/PushAddr    push a return address onto the RAS
//   PCResult         registered current PC
//   PCAddResult      PCResult + INCR (combinational)
//   Misaligned       PCResult not a multiple of INCR (combinational)
//   RasEmpty/RasFull RAS occupancy flags
//   RasOverflow/RasUnderflow  sticky error flags, cleared only by reset
module pc_sequencer #(
   parameter int unsigned      WIDTH     = 32,
   parameter int unsigned      INCR      = 4,
   parameter logic [WIDTH-1:0] RESET_VEC = '0,
   parameter int unsigned      RAS_DEPTH = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Stall,
   input  logic             BranchTaken,
   input  logic [WIDTH-1:0] BranchTarget,
   input  logic             Jump,
   input  logic [WIDTH-1:0] JumpTarget,
   input  logic             Ret,
   input  logic             Push,
   input  logic [WIDTH-1:0] PushAddr,
   output logic [WIDTH-1:0] PCResult,
   output logic [WIDTH-1:0] PCAddResult,
   output logic             Misaligned,
   output logic             RasEmpty,
   output logic             RasFull,
   output logic             RasOverflow,
   output logic             RasUnderflow
);

   localparam int unsigned      PTR_W      = $clog2(RAS_DEPTH);
   localparam int unsigned      CNT_W      = $clog2(RAS_DEPTH + 1);
   localparam logic [WIDTH-1:0] INCR_V     = WIDTH'(INCR);
   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INCR - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(RAS_DEPTH);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0] top_q, top_d, wr_ptr;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;
   logic             ras_write, pop_ok;

   // Occupancy flags straight from the registered count
   assign RasEmpty     = (count_q == '0);
   assign RasFull      = (count_q == CNT_MAX);
   assign RasOverflow  = ovf_q;
   assign RasUnderflow = unf_q;

   // Zero-latency views of the current PC
   assign PCResult    = pc_q;
   assign PCAddResult = pc_q + INCR_V;
   assign Misaligned  = ((pc_q & ALIGN_MASK) != '0);

   // RAS bookkeeping; runs whether or not Ret wins the redirect priority
   always_comb begin
      top_d     = top_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      ras_write = 1'b0;
      pop_ok    = 1'b0;
      wr_ptr    = top_q + PTR_W'(1);
      if (Push && Ret && !RasEmpty) begin
         // Swap: return to the old top, replace it with the new address
         ras_write = 1'b1;
         wr_ptr    = top_q;
         pop_ok    = 1'b1;
      end else if (Push) begin
         // A full stack silently drops its oldest entry (circular overwrite)
         ras_write = 1'b1;
         top_d     = top_q + PTR_W'(1);
         if (RasFull) ovf_d = 1'b1;
         else         count_d = count_q + CNT_W'(1);
         if (Ret)     unf_d = 1'b1;
      end else if (Ret) begin
         if (RasEmpty) begin
            unf_d = 1'b1;
         end else begin
            pop_ok  = 1'b1;
            top_d   = top_q - PTR_W'(1);
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   // Next-PC priority mux
   always_comb begin
      pc_d = pc_q + INCR_V;
      if (BranchTaken)     pc_d = BranchTarget;
      else if (Jump)       pc_d = JumpTarget;
      else if (pop_ok)     pc_d = ras_mem[top_q];
      else if (Stall)      pc_d = pc_q;
   end

   // PC, pointers and sticky flags
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pc_q    <= RESET_VEC;
         top_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         top_q   <= top_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Entry storage has no reset; writes are suppressed while in reset
   always_ff @(posedge Clk) begin
      if (Reset && ras_write) ras_mem[wr_ptr] <= PushAddr;
   end

endmodule

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps
// tb_pc_sequencer: directed scenarios plus randomized traffic checked against
// a queue-based model of the return-address stack and next-PC priority.
module tb_pc_sequencer;

   localparam int unsigned DEPTH = 4;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Stall, BranchTaken, Jump, Ret, Push;
   logic [31:0] BranchTarget, JumpTarget, PushAddr;
   logic [31:0] PCResult, PCAddResult;
   logic        Misaligned, RasEmpty, RasFull, RasOverflow, RasUnderflow;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   // Reference state
   logic [31:0] m_pc;
   logic [31:0] m_ras [$];
   logic        m_ovf, m_unf;

   pc_sequencer #(.WIDTH(32), .INCR(4), .RESET_VEC(32'h0), .RAS_DEPTH(DEPTH)) dut (
      .Clk(Clk), .Reset(Reset), .Stall(Stall),
      .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
      .Jump(Jump), .JumpTarget(JumpTarget),
      .Ret(Ret), .Push(Push), .PushAddr(PushAddr),
      .PCResult(PCResult), .PCAddResult(PCAddResult), .Misaligned(Misaligned),
      .RasEmpty(RasEmpty), .RasFull(RasFull),
      .RasOverflow(RasOverflow), .RasUnderflow(RasUnderflow)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc"},    PCResult, m_pc);
      check({tag, ".pc4"},   PCAddResult, m_pc + 32'd4);
      check({tag, ".mis"},   32'(Misaligned), 32'(m_pc[1:0] != 2'b00));
      check({tag, ".empty"}, 32'(RasEmpty), 32'(m_ras.size() == 0));
      check({tag, ".full"},  32'(RasFull), 32'(m_ras.size() == DEPTH));
      check({tag, ".ovf"},   32'(RasOverflow), 32'(m_ovf));
      check({tag, ".unf"},   32'(RasUnderflow), 32'(m_unf));
   endtask

   task automatic model_reset();
      m_pc = 32'h0;
      m_ras.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   // Architectural effect of one clock edge
   task automatic model_edge();
      logic        have_ret;
      logic [31:0] ret_addr;
      have_ret = 1'b0;
      ret_addr = 32'h0;
      if (Ret && m_ras.size() > 0) begin
         have_ret = 1'b1;
         ret_addr = m_ras[$];
         if (Push) m_ras[$] = PushAddr;
         else      void'(m_ras.pop_back());
      end else begin
         if (Ret) m_unf = 1'b1;
         if (Push) begin
            m_ras.push_back(PushAddr);
            if (m_ras.size() > DEPTH) begin
               m_ras.delete(0);
               m_ovf = 1'b1;
            end
         end
      end
      if (BranchTaken)   m_pc = BranchTarget;
      else if (Jump)     m_pc = JumpTarget;
      else if (have_ret) m_pc = ret_addr;
      else if (!Stall)   m_pc = m_pc + 32'd4;
   endtask

   task automatic drive(input logic st, input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt,
                        input logic rt, input logic ps, input logic [31:0] pa);
      Stall = st; BranchTaken = br; BranchTarget = bt;
      Jump = jp; JumpTarget = jt; Ret = rt; Push = ps; PushAddr = pa;
   endtask

   task automatic step(input string tag);
      @(posedge Clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step(tag);
   endtask

   // Async reset mid-cycle: must take effect without a clock edge
   task automatic do_reset(input string tag);
      @(negedge Clk);
      #2;
      Reset = 1'b0;
      model_reset();
      #1;
      check_all({tag, ".async"});
      @(posedge Clk);
      #1;
      check_all({tag, ".held"});
      @(negedge Clk);
      Reset = 1'b1;
      #1;
   endtask

   initial begin
      Reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge Clk);
      #1;
      check_all("rst");
      @(negedge Clk);
      Reset = 1'b1;
      #1;
      check_all("rel");

      // Sequential increment
      idle("seq1"); idle("seq2"); idle("seq3");

      // Stall, then redirect overriding stall
      drive(0, 0, 0, 1, 32'h10, 0, 0, 0);      step("jmp10");
      drive(1, 0, 0, 0, 0, 0, 0, 0);           step("stall1");
      step("stall2");
      drive(1, 1, 32'h80, 0, 0, 0, 0, 0);      step("stallbr");

      // Branch beats jump and ret, but ret still pops
      drive(0, 0, 0, 0, 0, 0, 1, 32'h40);      step("push40");
      drive(0, 1, 32'h100, 1, 32'h200, 1, 0, 0); step("brjr");

      // Push/pop and underflow
      drive(0, 0, 0, 0, 0, 0, 1, 32'hA0);      step("pushA0");
      drive(0, 0, 0, 0, 0, 0, 1, 32'hB0);      step("pushB0");
      drive(0, 0, 0, 0, 0, 1, 0, 0);           step("ret1");
      step("ret2");
      step("ret3unf");

      // Overflow wraps over oldest entry
      for (int i = 1; i <= 5; i++) begin
         drive(0, 0, 0, 0, 0, 0, 1, 32'(i * 4));
         step("pushov");
      end
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) step("popov");

      // PC wrap and misalignment
      drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0); step("jmpff");
      idle("wrap");
      drive(0, 0, 0, 1, 32'h102, 0, 0, 0);     step("mis");
      idle("mis2");

      do_reset("rst2");

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] bt, jt, pa;
         bt = $urandom & 32'hFFFF_FFFC;
         jt = $urandom & 32'hFFFF_FFFC;
         pa = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 15) == 0) jt = $urandom;
         drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0), bt,
               1'($urandom_range(0, 9) == 0), jt,
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), pa);
         step("rnd");
         if ($urandom_range(0, 299) == 0) do_reset("rndrst");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
